// File: rtl/mult_pkg.sv
// Shared widths and types for the shared-multiplier scheduler.
package mult_pkg;

  localparam int OP_W   = 24;
  localparam int PROD_W = 2 * OP_W;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin grant over NUM_REQ requesters; owns the rotating
// priority pointer, which moves past the winner whenever a grant is taken.
module mult_rr_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              pos;

  // Scan from ptr_q upward, wrapping, and keep the first asserted request.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    pos         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && ((req_i >> pos) & NUM_REQ'(1)) != '0) begin
        found       = 1'b1;
        grant_o     = NUM_REQ'(1) << pos;
        grant_idx_o = ID_W'(pos);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      if (int'(grant_idx_o) == NUM_REQ - 1) ptr_d = '0;
      else                                  ptr_d = grant_idx_o + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mult_share_sched.sv
// Shares one OP_W x OP_W unsigned multiplier among NUM_REQ requesters through
// a two-stage pipeline (operand register, product register) with backpressure.
module mult_share_sched
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = mult_pkg::OP_W,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [2*OP_W-1:0]       resp_data,
  output logic                    busy
);

  localparam int PRD_W = 2 * OP_W;

  logic                    adv;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic [NUM_REQ*OP_W-1:0] mask_a, mask_b;
  logic [OP_W-1:0]         sel_a, sel_b;

  logic                    s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]         s1_id_q, s1_id_d;
  logic [OP_W-1:0]         s1_a_q, s1_a_d;
  logic [OP_W-1:0]         s1_b_q, s1_b_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]         s2_id_q, s2_id_d;
  logic [PRD_W-1:0]        s2_prod_q, s2_prod_d;

  // The whole pipeline moves together; a stalled output freezes both stages.
  assign adv = !s2_valid_q || resp_ready;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_valid),
    .adv_i       (adv),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = rst_n ? (grant & {NUM_REQ{adv}}) : '0;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
    assign mask_a[gi*OP_W +: OP_W] = req_a[gi*OP_W +: OP_W] & {OP_W{grant[gi]}};
    assign mask_b[gi*OP_W +: OP_W] = req_b[gi*OP_W +: OP_W] & {OP_W{grant[gi]}};
  end

  // Grant is one-hot, so OR-reducing the masked lanes selects the winner.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a = sel_a | OP_W'(mask_a >> (i * OP_W));
      sel_b = sel_b | OP_W'(mask_b >> (i * OP_W));
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s2_valid_d = s2_valid_q;
    s2_id_d    = s2_id_q;
    s2_prod_d  = s2_prod_q;
    if (adv) begin
      s1_valid_d = |grant;
      if (|grant) begin
        s1_id_d = grant_idx;
        s1_a_d  = sel_a;
        s1_b_d  = sel_b;
      end
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_id_d   = s1_id_q;
        s2_prod_d = PRD_W'(s1_a_q) * PRD_W'(s1_b_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_prod_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_id_q    <= s1_id_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_prod_q  <= s2_prod_d;
    end
  end

  assign resp_valid = s2_valid_q;
  assign resp_id    = s2_id_q;
  assign resp_data  = s2_prod_q;
  assign busy       = s1_valid_q || s2_valid_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  a_resp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_id) && $stable(resp_data)));

endmodule
